icc_branch_unit: RTL and testbench
==================================

ICC_BRANCH_UNIT -- requirements
Module: icc_branch_unit

Interface
REQ-001 The module SHALL have exactly one clock and synchronous active-high reset, ports listed first as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only at rising clk.
REQ-004 alu_op  input  6  opcode presented to the ALU this cycle.
REQ-005 alu_n, alu_z, alu_c, alu_v  input  1 each  ALU flag outputs for alu_op.
REQ-006 cc_en  input  1  ALU result this cycle is architecturally committed.
REQ-007 stall  input  1  pipeline freeze; all state holds.
REQ-008 br_valid  input  1  Bicc instruction present this cycle.
REQ-009 br_cond  input  4  Bicc cond field.
REQ-010 br_annul  input  1  Bicc annul (a) bit.
REQ-011 icc  output  4  registered {N,Z,V,C}.
REQ-012 ci  output  1  equals icc[0] (C); drives ALU carry-in for addx/subx.
REQ-013 taken  output  1  registered; high for one cycle after a taken branch is accepted.
REQ-014 squash  output  1  high while the delay-slot instruction is annulled.

Function
REQ-015 Flag write SHALL occur at a rising edge iff cc_en=1, alu_op[5:4]=2'b01, stall=0, state!=ANNUL; icc <= {alu_n,alu_z,alu_v,alu_c}.
REQ-016 Opcodes with alu_op[5:4]!=2'b01 (add, and, shifts, etc.) SHALL leave icc unchanged.
REQ-017 Branch evaluation SHALL use effective flags: ALU flags when a flag write (REQ-015) occurs in the same cycle, else icc (forwarding).
REQ-018 Conditions: 1000 always; 0000 never; 1001 ~Z; 0001 Z; 1010 ~(Z|(N^V)); 0010 Z|(N^V); 1011 ~(N^V); 0011 N^V; 1100 ~(C|Z); 0100 C|Z; 1101 ~C; 0101 C; 1110 ~N; 0110 N; 1111 ~V; 0111 V.
REQ-019 States: IDLE, DELAY, ANNUL; reset state IDLE.
REQ-020 A branch SHALL be accepted at an edge when br_valid=1, stall=0, state!=ANNUL; latency to taken/squash is one cycle.
REQ-021 On acceptance, taken <= condition result; next state ANNUL when br_annul=1 and (cond=1000 or result=0), else DELAY.
REQ-022 Without acceptance and stall=0, next state SHALL be IDLE and taken <= 0.
REQ-023 br_valid in DELAY (branch in delay slot) SHALL be accepted normally per REQ-021.
REQ-024 br_valid and cc_en in ANNUL SHALL be ignored (annulled instruction has no effect); state returns to IDLE.
REQ-025 squash SHALL equal (state==ANNUL); taken and squash SHALL be mutually exclusive except for cond=1000 with br_annul=1 (both high).
REQ-026 stall=1 SHALL hold icc, state, taken unchanged for every stalled cycle.
REQ-027 Reset SHALL take priority over stall, br_valid and cc_en.

Reset
REQ-028 On reset: icc=4'b0000, ci=0, taken=0, squash=0, state=IDLE, effective on the edge reset is sampled.
REQ-029 Reset mid-ANNUL or mid-DELAY SHALL clear squash/taken on that edge; no pending annul survives.

Verification
REQ-030 subcc alu_op=010100 with A=7,B=7 (N0 Z1 V0 C0), cc_en=1 -> next cycle icc=0100; then alu_op=000000 cc_en=1 with flags 1111 -> icc stays 0100.
REQ-031 Same-cycle subcc (Z=1) + br_valid cond=0001 a=0 -> next cycle taken=1, squash=0, state DELAY (forwarding).
REQ-032 icc=0100, br cond=1001 (BNE) a=1 -> taken=0, squash=1 for one cycle; cc_en with alu_op=010000 during that cycle -> icc unchanged.
REQ-033 br cond=1000 a=1 -> taken=1 and squash=1 one cycle; cond=0000 a=1 -> taken=0, squash=1.
REQ-034 Accept BE taken, assert stall 3 cycles -> taken holds 1 for all 3, icc frozen; release -> taken 0 next cycle.
REQ-035 Reset asserted during ANNUL with icc=1111 -> next cycle icc=0000, ci=0, squash=0, taken=0.

Source files
------------

// File: rtl/icc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : icc_branch_unit
// Brief    : Integer condition-code register with Bicc evaluation, flag
//            forwarding and delay-slot annul control.
// Revision : 1.0  initial release
// ============================================================================
module icc_branch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] alu_op,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       cc_en,
    input  logic       stall,
    input  logic       br_valid,
    input  logic [3:0] br_cond,
    input  logic       br_annul,
    output logic [3:0] icc,
    output logic       ci,
    output logic       taken,
    output logic       squash
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_ANNUL = 2'd2;

    localparam logic [3:0] C_COND_ALWAYS = 4'b1000;

    logic [1:0] r_state;
    logic [3:0] r_icc;
    logic       r_taken;

    logic       w_flag_wr;
    logic       w_accept;
    logic [3:0] w_eff;
    logic       w_n, w_z, w_v, w_c;
    logic       w_result;

    // Only the cc-setting opcode group writes flags; an annulled slot never does.
    assign w_flag_wr = cc_en && (alu_op[5:4] == 2'b01) && !stall && (r_state != S_ANNUL);
    assign w_accept  = br_valid && !stall && (r_state != S_ANNUL);

    // Forward this cycle's ALU flags so a branch right after a cc-op sees them.
    assign w_eff = w_flag_wr ? {alu_n, alu_z, alu_v, alu_c} : r_icc;
    assign w_n   = w_eff[3];
    assign w_z   = w_eff[2];
    assign w_v   = w_eff[1];
    assign w_c   = w_eff[0];

    always_comb begin
        w_result = 1'b0;
        case (br_cond[2:0])
            3'b000:  w_result = 1'b0;
            3'b001:  w_result = w_z;
            3'b010:  w_result = w_z | (w_n ^ w_v);
            3'b011:  w_result = w_n ^ w_v;
            3'b100:  w_result = w_c | w_z;
            3'b101:  w_result = w_c;
            3'b110:  w_result = w_n;
            3'b111:  w_result = w_v;
            default: w_result = 1'b0;
        endcase
        if (br_cond[3]) begin
            w_result = ~w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_icc   <= 4'b0000;
            r_state <= S_IDLE;
            r_taken <= 1'b0;
        end else if (!stall) begin
            if (w_flag_wr) begin
                r_icc <= {alu_n, alu_z, alu_v, alu_c};
            end
            if (w_accept) begin
                r_taken <= w_result;
                if (br_annul && ((br_cond == C_COND_ALWAYS) || !w_result)) begin
                    r_state <= S_ANNUL;
                end else begin
                    r_state <= S_DELAY;
                end
            end else begin
                r_taken <= 1'b0;
                r_state <= S_IDLE;
            end
        end
    end

    assign icc    = r_icc;
    assign ci     = r_icc[0];
    assign taken  = r_taken;
    assign squash = (r_state == S_ANNUL);

endmodule
`default_nettype wire

// File: tb/tb_icc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_icc_branch_unit
// Brief    : Table-driven self-checking bench with an expected-result queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_icc_branch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] alu_op;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       cc_en, stall, br_valid, br_annul;
    logic [3:0] br_cond;
    logic [3:0] icc;
    logic       ci, taken, squash;

    icc_branch_unit dut (
        .clk      (clk),
        .reset    (reset),
        .alu_op   (alu_op),
        .alu_n    (alu_n),
        .alu_z    (alu_z),
        .alu_c    (alu_c),
        .alu_v    (alu_v),
        .cc_en    (cc_en),
        .stall    (stall),
        .br_valid (br_valid),
        .br_cond  (br_cond),
        .br_annul (br_annul),
        .icc      (icc),
        .ci       (ci),
        .taken    (taken),
        .squash   (squash)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [3:0] fl;     // {N,Z,V,C}
        logic       cc;
        logic       st;
        logic       bv;
        logic [3:0] cond;
        logic       an;
        logic [3:0] e_icc;
        logic       e_t;
        logic       e_s;
    } vec_t;

    localparam logic [5:0] C_SUBCC = 6'b010100;
    localparam logic [5:0] C_ADD   = 6'b000000;

    vec_t tbl [0:20];
    vec_t exp_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;
    string tag;

    function automatic vec_t mk(logic rst, logic [5:0] op, logic [3:0] fl, logic cc,
                                logic st, logic bv, logic [3:0] cond, logic an,
                                logic [3:0] e_icc, logic e_t, logic e_s);
        vec_t v;
        v.rst = rst; v.op = op; v.fl = fl; v.cc = cc; v.st = st; v.bv = bv;
        v.cond = cond; v.an = an; v.e_icc = e_icc; v.e_t = e_t; v.e_s = e_s;
        return v;
    endfunction

    // Bicc truth table written out independently of the DUT structure.
    function automatic logic cond_model(logic [3:0] c, logic [3:0] f);
        logic n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b1001: return !z;
            4'b0001: return z;
            4'b1010: return !(z || (n != v));
            4'b0010: return z || (n != v);
            4'b1011: return n == v;
            4'b0011: return n != v;
            4'b1100: return !(cy || z);
            4'b0100: return cy || z;
            4'b1101: return !cy;
            4'b0101: return cy;
            4'b1110: return !n;
            4'b0110: return n;
            4'b1111: return !v;
            default: return v;
        endcase
    endfunction

    task automatic cmp(string name, logic [3:0] act, logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %b expected %b", tag, name, act, req);
        end
    endtask

    task automatic step(vec_t v, string t);
        vec_t e;
        @(negedge clk);
        reset = v.rst; alu_op = v.op; cc_en = v.cc; stall = v.st;
        {alu_n, alu_z, alu_v, alu_c} = v.fl;
        br_valid = v.bv; br_cond = v.cond; br_annul = v.an;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        tag = t;
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s scoreboard empty", t);
        end else begin
            e = exp_q.pop_front();
            cmp("icc",    icc,          e.e_icc);
            cmp("ci",     {3'b0, ci},     {3'b0, e.e_icc[0]});
            cmp("taken",  {3'b0, taken},  {3'b0, e.e_t});
            cmp("squash", {3'b0, squash}, {3'b0, e.e_s});
        end
    endtask

    initial begin
        logic [3:0] pats [0:5];
        reset = 1'b1; alu_op = '0; cc_en = 0; stall = 0;
        {alu_n, alu_z, alu_v, alu_c} = 4'b0;
        br_valid = 0; br_cond = '0; br_annul = 0;

        //            rst op       fl       cc st bv cond     an  icc      t  s
        tbl[0]  = mk(1, C_ADD,   4'b1111, 1, 1, 1, 4'b1000, 1, 4'b0000, 0, 0); // reset wins
        tbl[1]  = mk(0, C_SUBCC, 4'b0100, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        tbl[2]  = mk(0, C_ADD,   4'b1111, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        tbl[3]  = mk(0, C_SUBCC, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
        tbl[4]  = mk(0, C_SUBCC, 4'b0100, 1, 0, 1, 4'b0001, 0, 4'b0100, 1, 0); // forwarding
        tbl[5]  = mk(0, C_ADD,   4'b0000, 0, 0, 1, 4'b1001, 1, 4'b0100, 0, 1); // BNE,a in slot
        tbl[6]  = mk(0, 6'b010000, 4'b1111, 1, 0, 1, 4'b1000, 0, 4'b0100, 0, 0); // ignored
        tbl[7]  = mk(0, C_ADD,   4'b0000, 0, 0, 1, 4'b1000, 1, 4'b0100, 1, 1);
        tbl[8]  = mk(0, C_ADD,   4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        tbl[9]  = mk(0, C_ADD,   4'b0000, 0, 0, 1, 4'b0000, 1, 4'b0100, 0, 1);
        tbl[10] = mk(0, C_ADD,   4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        tbl[11] = mk(0, C_ADD,   4'b0000, 0, 0, 1, 4'b0001, 0, 4'b0100, 1, 0); // BE taken
        tbl[12] = mk(0, C_SUBCC, 4'b1111, 1, 1, 1, 4'b0000, 1, 4'b0100, 1, 0); // stall x3
        tbl[13] = mk(0, C_SUBCC, 4'b1111, 1, 1, 1, 4'b0000, 1, 4'b0100, 1, 0);
        tbl[14] = mk(0, C_SUBCC, 4'b1111, 1, 1, 0, 4'b0000, 0, 4'b0100, 1, 0);
        tbl[15] = mk(0, C_ADD,   4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0100, 0, 0);
        tbl[16] = mk(0, C_SUBCC, 4'b1111, 1, 0, 0, 4'b0000, 0, 4'b1111, 0, 0);
        tbl[17] = mk(0, C_ADD,   4'b0000, 0, 0, 1, 4'b0000, 1, 4'b1111, 0, 1); // into ANNUL
        tbl[18] = mk(1, C_ADD,   4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0); // reset mid-ANNUL
        tbl[19] = mk(0, C_ADD,   4'b0000, 0, 0, 1, 4'b1000, 0, 4'b0000, 1, 0); // into DELAY
        tbl[20] = mk(1, C_ADD,   4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0000, 0, 0); // reset mid-DELAY

        for (int i = 0; i < 21; i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Every condition against several flag sets, flags forwarded same cycle.
        pats[0] = 4'b1000; pats[1] = 4'b0010; pats[2] = 4'b0100;
        pats[3] = 4'b0001; pats[4] = 4'b1010; pats[5] = 4'b1111;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 16; c++) begin
                step(mk(0, C_SUBCC, pats[p], 1, 0, 1, 4'(c), 0,
                        pats[p], cond_model(4'(c), pats[p]), 0),
                     $sformatf("cond%b_f%b", 4'(c), pats[p]));
            end
        end

        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard leftover %0d expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
